// File: rtl/uart_tx_scheduler.sv
// UART transmit controller: round-robin merge of CPU and echo bytes into a
// small FIFO, then 8N1 serialisation at CLKS_PER_BIT sysclk cycles per bit.
module uart_tx_scheduler #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          cpu_valid,
  input  logic [7:0]                    cpu_data,
  output logic                          cpu_ready,
  input  logic                          echo_valid,
  input  logic [7:0]                    echo_data,
  output logic                          echo_ready,
  input  logic                          tx_enable,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned CNT_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [OCC_W-1:0] FULL_VAL = OCC_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             r_last_echo;

  // Serialiser state
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_busy;
  logic             r_stop_last;
  logic             r_done;

  logic             w_full;
  logic             w_grant_cpu;
  logic             w_grant_echo;
  logic             w_push;
  logic [7:0]       w_push_data;
  logic             w_pop;
  logic             w_bit_end;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_bit_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_tx_nxt;
  logic             w_stop_last;

  // Round-robin grant; with no requester the grant still points at the
  // side that was not served last, so ready can be high before valid.
  always_comb begin
    w_full       = (r_count == FULL_VAL);
    w_grant_cpu  = cpu_valid ? (~echo_valid | r_last_echo)
                             : (~echo_valid & r_last_echo);
    w_grant_echo = ~w_grant_cpu;
    cpu_ready    = w_grant_cpu  & ~w_full & ~reset;
    echo_ready   = w_grant_echo & ~w_full & ~reset;
    w_push       = (cpu_valid & cpu_ready) | (echo_valid & echo_ready);
    w_push_data  = w_grant_cpu ? cpu_data : echo_data;
  end

  always_ff @(posedge sysclk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last_echo <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
        r_last_echo <= w_grant_echo;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register and serialiser datapath registers
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_stop_last <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_tx        <= w_tx_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_stop_last <= w_stop_last;
      r_done      <= r_stop_last;
    end
  end

  // Next-state logic; the line level follows the current state one cycle
  // later, so tx_done is delayed to line up with the end of the stop bit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = 1'b1;
    w_pop       = 1'b0;
    w_stop_last = 1'b0;
    w_bit_end   = (r_cnt == CNT_LAST);

    case (r_state)
      S_IDLE: begin
        if (tx_enable && (r_count != '0)) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx_nxt  = 1'b0;
        w_cnt_nxt = w_bit_end ? '0 : r_cnt + CNT_W'(1);
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_tx_nxt  = r_shift[0];
        w_cnt_nxt = w_bit_end ? '0 : r_cnt + CNT_W'(1);
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end
      end
      S_STOP: begin
        w_tx_nxt  = 1'b1;
        w_cnt_nxt = w_bit_end ? '0 : r_cnt + CNT_W'(1);
        if (w_bit_end) begin
          w_stop_last = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign tx         = r_tx;
  assign tx_busy    = r_busy;
  assign tx_done    = r_done;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler at CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_scheduler;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic       sysclk;
  logic       reset;
  logic       cpu_valid;
  logic [7:0] cpu_data;
  logic       cpu_ready;
  logic       echo_valid;
  logic [7:0] echo_data;
  logic       echo_ready;
  logic       tx_enable;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  uart_tx_scheduler #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .cpu_valid  (cpu_valid),
    .cpu_data   (cpu_data),
    .cpu_ready  (cpu_ready),
    .echo_valid (echo_valid),
    .echo_data  (echo_data),
    .echo_ready (echo_ready),
    .tx_enable  (tx_enable),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sysclk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_fall(input string tag, output int at);
    int k;
    k = 0;
    while (tx !== 1'b0 && k < 200) begin
      tick(1);
      k++;
    end
    if (tx !== 1'b0) chk({tag, "_timeout"}, 32'(tx), 32'd0);
    at = cyc;
  endtask

  // Samples the middle of each bit; returns on the 3rd cycle of the stop bit.
  task automatic get_frame(input string tag, input logic [7:0] exp, output int at);
    logic [7:0] b;
    b = '0;
    wait_fall(tag, at);
    tick(2);
    chk({tag, "_start"}, 32'(tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick(CPB);
      b[i] = tx;
    end
    chk({tag, "_data"}, 32'(b), 32'(exp));
    tick(CPB);
    chk({tag, "_stop"}, 32'(tx), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         at;
    int         prev;
    int         k;
    logic [9:0] fr;

    // 1: reset with both requesters valid
    reset      = 1'b1;
    tx_enable  = 1'b0;
    cpu_valid  = 1'b1;
    echo_valid = 1'b1;
    cpu_data   = 8'h77;
    echo_data  = 8'h66;
    tick(1);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_cnt", 32'(fifo_count), 32'd0);
    tick(1);
    chk("rst_tx2", 32'(tx), 32'd1);
    chk("rst_cnt2", 32'(fifo_count), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_tx", 32'(tx), 32'd1);
    chk("rel_busy", 32'(tx_busy), 32'd0);
    chk("rel_cnt", 32'(fifo_count), 32'd0);
    chk("rel_cpu_ready", 32'(cpu_ready), 32'd1);
    chk("rel_echo_ready", 32'(echo_ready), 32'd0);
    cpu_valid  = 1'b0;
    echo_valid = 1'b0;

    // 2: single CPU byte 0xA5
    tx_enable = 1'b1;
    cpu_data  = 8'hA5;
    cpu_valid = 1'b1;
    #1;
    chk("t2_ready", 32'(cpu_ready), 32'd1);
    tick(1);
    cpu_valid = 1'b0;
    chk("t2_cnt1", 32'(fifo_count), 32'd1);
    chk("t2_tx_idle", 32'(tx), 32'd1);
    tick(1);
    chk("t2_busy", 32'(tx_busy), 32'd1);
    chk("t2_tx_pop", 32'(tx), 32'd1);
    chk("t2_cnt0", 32'(fifo_count), 32'd0);
    tick(1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < FRAME; i++) begin
      chk("t2_bit", 32'(tx), 32'(fr[i / CPB]));
      chk("t2_no_done", 32'(tx_done), 32'd0);
      tick(1);
    end
    chk("t2_done", 32'(tx_done), 32'd1);
    chk("t2_busy_end", 32'(tx_busy), 32'd0);
    chk("t2_cnt_end", 32'(fifo_count), 32'd0);
    tick(1);
    chk("t2_done_pulse", 32'(tx_done), 32'd0);

    // 3: fill with alternating grants while transmit is disabled
    reset = 1'b1;
    tick(1);
    reset      = 1'b0;
    tx_enable  = 1'b0;
    cpu_data   = 8'h11;
    echo_data  = 8'h22;
    cpu_valid  = 1'b1;
    echo_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_cpu_ready", 32'(cpu_ready), 32'((i % 2) == 0));
      chk("t3_echo_ready", 32'(echo_ready), 32'((i % 2) == 1));
      tick(1);
      chk("t3_cnt", 32'(fifo_count), 32'(i + 1));
    end
    chk("t3_full_cpu", 32'(cpu_ready), 32'd0);
    chk("t3_full_echo", 32'(echo_ready), 32'd0);

    // 4: drain in order while refilling
    tx_enable = 1'b1;
    tick(1);
    chk("t4_pop_cnt", 32'(fifo_count), 32'd3);
    chk("t4_refill_cpu", 32'(cpu_ready), 32'd1);
    chk("t4_refill_echo", 32'(echo_ready), 32'd0);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      get_frame("t4_frame", (i % 2 == 0) ? 8'h11 : 8'h22, at);
      if (i > 0) chk("t4_gap", 32'(at - prev), 32'(FRAME + 1));
      prev = at;
    end
    tx_enable  = 1'b0;
    cpu_valid  = 1'b0;
    echo_valid = 1'b0;
    tick(4);
    chk("t4_refilled", 32'(fifo_count), 32'd4);
    chk("t4_idle", 32'(tx_busy), 32'd0);
    tx_enable = 1'b1;
    get_frame("t4_refill0", 8'h11, at);
    get_frame("t4_refill1", 8'h22, at);
    tx_enable = 1'b0;
    tick(4);

    // 5: drop tx_enable mid-frame
    reset = 1'b1;
    tick(1);
    reset     = 1'b0;
    tx_enable = 1'b1;
    cpu_valid = 1'b1;
    cpu_data  = 8'h3C;
    #1;
    tick(1);
    cpu_data = 8'h5A;
    tick(1);
    cpu_data = 8'h81;
    tick(1);
    cpu_valid = 1'b0;
    chk("t5_fall", 32'(tx), 32'd0);
    chk("t5_cnt", 32'(fifo_count), 32'd2);
    tick(10);
    tx_enable = 1'b0;
    k = 0;
    while (tx_done !== 1'b1 && k < 60) begin
      tick(1);
      k++;
    end
    chk("t5_done", 32'(tx_done), 32'd1);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("t5_hold_tx", 32'(tx), 32'd1);
      chk("t5_hold_cnt", 32'(fifo_count), 32'd2);
      chk("t5_hold_busy", 32'(tx_busy), 32'd0);
    end
    tx_enable = 1'b1;
    tick(1);
    chk("t5_resume_busy", 32'(tx_busy), 32'd1);
    chk("t5_resume_cnt", 32'(fifo_count), 32'd1);

    // 6: reset during DATA of a 0xFF frame with one byte still queued
    reset = 1'b1;
    tick(1);
    reset     = 1'b0;
    tx_enable = 1'b1;
    cpu_valid = 1'b1;
    cpu_data  = 8'hFF;
    #1;
    tick(1);
    cpu_data = 8'h00;
    tick(1);
    cpu_valid = 1'b0;
    tick(1);
    chk("t6_fall", 32'(tx), 32'd0);
    chk("t6_cnt", 32'(fifo_count), 32'd1);
    tick(10);
    chk("t6_busy", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t6_rst_tx", 32'(tx), 32'd1);
    chk("t6_rst_busy", 32'(tx_busy), 32'd0);
    chk("t6_rst_cnt", 32'(fifo_count), 32'd0);
    chk("t6_rst_done", 32'(tx_done), 32'd0);
    for (int i = 0; i < 45; i++) begin
      tick(1);
      chk("t6_no_done", 32'(tx_done), 32'd0);
      chk("t6_line_high", 32'(tx), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Transmit-side controller for the board UART.
- Arbitrates two byte producers into a shared transmit FIFO: the CPU store path to the UART data register, and the RX echo path.
- Sequences 8N1 serialisation on the tx pin using an internal bit-period counter, whose default rate is 9600 baud at 100 MHz.
- Reports busy, completion and FIFO occupancy to the peripheral status register.

Parameters:
- CLKS_PER_BIT, 10416: sysclk cycles per serial bit; minimum value 2.
- FIFO_DEPTH, 4: transmit FIFO entries; must be a power of two and at least 2.

Ports:
- sysclk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_valid  input  1  CPU offers cpu_data.
- cpu_data  input  8  CPU byte.
- cpu_ready  output  1  CPU byte accepted this cycle when high together with cpu_valid.
- echo_valid  input  1  echo path offers echo_data.
- echo_data  input  8  echo byte.
- echo_ready  output  1  echo byte accepted this cycle when high together with echo_valid.
- tx_enable  input  1  permits starting new frames.
- tx  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is in progress (any state other than IDLE).
- tx_done  output  1  one-cycle pulse at the end of the stop bit.
- fifo_count  output  clog2(FIFO_DEPTH)+1  number of FIFO entries.

Behaviour:
- Reset (sampled at the sysclk edge, wins over all other inputs):
  - tx=1, tx_busy=0, tx_done=0, fifo_count=0.
  - FIFO pointers cleared; FSM goes to IDLE; bit counter cleared.
  - Last-grant pointer set to ECHO, so the CPU wins the first tie.
  - A frame in flight is abandoned and tx goes high on the next edge.
- Arbitration (combinational ready, registered state):
  - full = (fifo_count == FIFO_DEPTH).
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted last is granted.
  - x_ready = grant_x & ~full. The non-granted ready is 0.
  - Ready may be high while valid is low; ready is not registered.
  - On a transfer (valid & ready), the byte is written at the write pointer and the last-grant pointer updates.
  - At most one enqueue per cycle.
  - The requester must hold its data stable while valid and not ready.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - Pop happens only from IDLE.
  - Simultaneous push and pop leaves fifo_count unchanged. Push into a FIFO full at cycle start is impossible because ready is 0.
  - Pop from an empty FIFO never occurs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If tx_enable & fifo_count!=0, pop the head into an 8-bit shift register, clear the bit counter and bit index, and move to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit. After 8 bits go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle, assert tx_done for one cycle and go to IDLE.
- Timing and latency:
  - tx is registered.
  - Byte accepted at edge N with an idle, empty FIFO: pop at edge N+1, tx low from edge N+2.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly one IDLE cycle between them, with tx high.
  - The bit counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- tx_enable is checked only in IDLE. Deasserting it mid-frame lets the current frame complete; the FIFO keeps filling.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Assert reset for 2 cycles with cpu_valid=echo_valid=1 -> during reset, no enqueue and tx=1. After release: tx=1, tx_busy=0, fifo_count=0, cpu_ready=1, echo_ready=0.
2. With tx_enable=1, send CPU byte 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. tx low starts 2 cycles after acceptance. tx_done pulses once, 40 cycles after tx falls. fifo_count returns to 0.
3. With tx_enable=0, hold cpu_valid (0x11) and echo_valid (0x22) continuously -> accepts alternate CPU, echo, CPU, echo over 4 cycles. fifo_count reaches 4, then both readies are 0.
4. Continue from 3 and set tx_enable=1 -> frames 0x11, 0x22, 0x11, 0x22 in order, with one idle cycle between frames. Freed slots are refilled alternately, starting with CPU.
5. Drop tx_enable 10 cycles into a 0x3C frame with 2 more bytes queued -> the 0x3C frame completes with tx_done. tx stays 1, fifo_count stays 2, and tx_busy=0 until tx_enable returns.
6. Assert reset during DATA of a 0xFF frame -> tx=1 and tx_busy=0 the next cycle, fifo_count=0, and no tx_done pulse.
